mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit.sv | 169 ++++++++++++++++
 tb/tb_mul_div_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// RV32M iterative multiply/divide unit, one radix-2 step per clock.
// Ports: clk, rst (async high), start/funct3/dataA/dataB in; busy/done/result out.
module mul_div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t      r_state;
  logic [5:0]  r_cnt;
  logic [2:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_acc;
  logic        r_neg;
  logic        r_divz;
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_result;

  // operand decode at accept time
  logic        w_sa;
  logic        w_sb;
  logic        w_na;
  logic        w_nb;
  logic [31:0] w_ma;
  logic [31:0] w_mb;
  logic        w_neg_in;

  always_comb begin
    w_sa = 1'b0;
    w_sb = 1'b0;
    unique case (funct3)
      3'b001: begin w_sa = 1'b1; w_sb = 1'b1; end
      3'b010: w_sa = 1'b1;
      3'b100: begin w_sa = 1'b1; w_sb = 1'b1; end
      3'b110: begin w_sa = 1'b1; w_sb = 1'b1; end
      default: ;
    endcase
  end

  assign w_na = w_sa & dataA[31];
  assign w_nb = w_sb & dataB[31];
  assign w_ma = w_na ? -dataA : dataA;
  assign w_mb = w_nb ? -dataB : dataB;

  // remainder sign follows the dividend only
  always_comb begin
    w_neg_in = 1'b0;
    unique case (funct3)
      3'b001:  w_neg_in = w_na ^ w_nb;
      3'b010:  w_neg_in = w_na;
      3'b100:  w_neg_in = w_na ^ w_nb;
      3'b110:  w_neg_in = w_na;
      default: w_neg_in = 1'b0;
    endcase
  end

  // one iteration step
  logic        w_is_div;
  logic [32:0] w_msum;
  logic [32:0] w_rsh;
  logic        w_rge;
  logic [31:0] w_rsub;
  logic [31:0] w_acc_nx;
  logic [31:0] w_b_nx;

  assign w_is_div = r_op[2];
  assign w_msum   = {1'b0, r_acc} + (r_b[0] ? {1'b0, r_a} : 33'd0);
  assign w_rsh    = {r_acc, r_b[31]};
  assign w_rge    = w_rsh >= {1'b0, r_a};
  assign w_rsub   = w_rsh[31:0] - r_a;
  assign w_acc_nx = w_is_div ? (w_rge ? w_rsub : w_rsh[31:0])
                             : w_msum[32:1];
  assign w_b_nx   = w_is_div ? {r_b[30:0], w_rge}
                             : {w_msum[0], r_b[31:1]};

  // sign correction applied on the final step
  logic [63:0] w_prod;
  logic [63:0] w_prod_s;
  logic [31:0] w_q;
  logic [31:0] w_r;
  logic [31:0] w_res;

  assign w_prod   = {w_acc_nx, w_b_nx};
  assign w_prod_s = r_neg ? -w_prod : w_prod;
  assign w_q      = r_neg ? -w_b_nx : w_b_nx;
  assign w_r      = r_neg ? -w_acc_nx : w_acc_nx;

  // divide-by-zero remainder falls out naturally; only the
  // signed quotient needs forcing to all ones
  always_comb begin
    w_res = 32'd0;
    unique case (r_op)
      3'b000:  w_res = w_prod_s[31:0];
      3'b001:  w_res = w_prod_s[63:32];
      3'b010:  w_res = w_prod_s[63:32];
      3'b011:  w_res = w_prod_s[63:32];
      3'b100:  w_res = r_divz ? 32'hFFFF_FFFF : w_q;
      3'b101:  w_res = w_b_nx;
      3'b110:  w_res = w_r;
      default: w_res = w_acc_nx;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 6'd0;
      r_op     <= 3'd0;
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_acc    <= 32'd0;
      r_neg    <= 1'b0;
      r_divz   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= 32'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_CALC: begin
          r_acc <= w_acc_nx;
          r_b   <= w_b_nx;
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == 6'd31) begin
            r_state  <= S_DONE;
            r_cnt    <= 6'd0;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_result <= w_res;
          end
        end
        default: begin
          if (start) begin
            r_state <= S_CALC;
            r_cnt   <= 6'd0;
            r_op    <= funct3;
            r_neg   <= w_neg_in;
            r_divz  <= (dataB == 32'd0);
            r_acc   <= 32'd0;
            r_a     <= funct3[2] ? w_mb : w_ma;
            r_b     <= funct3[2] ? w_ma : w_mb;
            r_busy  <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: vector table, random ops
// against an arithmetic model, and protocol corner sequences.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] dataA = 32'd0;
  logic [31:0] dataB = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_tests = 0;
  int n_fail  = 0;

  mul_div_unit dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .dataA(dataA), .dataB(dataB),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  function automatic logic [31:0] model(logic [2:0] op,
                                        logic [31:0] a,
                                        logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    p = 64'd0;
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((busy || done) && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 200) check("idle_timeout", 32'd1, 32'd0);
  endtask

  // Issue one op and check exact latency, result hold and value.
  task automatic do_op(string name, logic [2:0] op,
                       logic [31:0] a, logic [31:0] b,
                       logic [31:0] exp);
    logic [31:0] prev;
    int bad;
    @(negedge clk);
    prev = result;
    start = 1'b1; funct3 = op; dataA = a; dataB = b;
    @(posedge clk); #1;
    start = 1'b0;
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      if (!busy || done || result !== prev) bad++;
      @(posedge clk); #1;
    end
    if (!done || busy) bad++;
    check({name, "_timing"}, bad, 0);
    check(name, result, exp);
  endtask

  vec_t vt[$];

  initial begin
    vt.push_back('{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB});
    vt.push_back('{3'd1, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF});
    vt.push_back('{3'd3, 32'h0000_0007, 32'hFFFF_FFFD, 32'h0000_0006});
    vt.push_back('{3'd2, 32'h0000_0007, 32'hFFFF_FFFD, 32'h0000_0006});
    vt.push_back('{3'd4, 32'hFFFF_FFEC, 32'h0000_0003, 32'hFFFF_FFFA});
    vt.push_back('{3'd6, 32'hFFFF_FFEC, 32'h0000_0003, 32'hFFFF_FFFE});
    vt.push_back('{3'd5, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E});
    vt.push_back('{3'd7, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002});
    vt.push_back('{3'd5, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF});
    vt.push_back('{3'd6, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678});
    vt.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000});
    vt.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000});
    vt.push_back('{3'd4, 32'hFFFF_FFEC, 32'h0000_0000, 32'hFFFF_FFFF});
    vt.push_back('{3'd7, 32'hFFFF_FFEC, 32'h0000_0000, 32'hFFFF_FFEC});
    vt.push_back('{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000});
    vt.push_back('{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000});
    vt.push_back('{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE});
    vt.push_back('{3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000});
    vt.push_back('{3'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000});
    vt.push_back('{3'd6, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001});
    vt.push_back('{3'd4, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD});
  end

  initial begin
    int bad;
    int ndone;
    int k;
    logic [2:0]  op;
    logic [31:0] a, b;

    // reset state, with start held high during reset
    start = 1'b1; funct3 = 3'd0; dataA = 32'd3; dataB = 32'd5;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    @(negedge clk);
    start = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_idle", {31'd0, busy}, 32'd0);

    foreach (vt[i]) begin
      do_op($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].exp);
      @(posedge clk); #1;
      check($sformatf("vec%0d_pulse", i), {31'd0, done}, 32'd0);
    end

    // randomized ops against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      k = $urandom_range(0, 9);
      if (k == 0) b = 32'd0;
      if (k == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      if (k == 2) b = 32'($urandom_range(1, 15));
      do_op($sformatf("rnd%0d", i), op, a, b, model(op, a, b));
    end
    wait_idle();

    // start re-pulsed during CALC is ignored
    @(negedge clk);
    start = 1'b1; funct3 = 3'd0; dataA = 32'h0000_1234; dataB = 32'h0000_5678;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0;
    bad = 0;
    for (int c = 1; c <= 72; c++) begin
      @(negedge clk);
      if (c == 5 || c == 20) begin
        start = 1'b1; funct3 = 3'd5; dataA = 32'hDEAD_BEEF; dataB = 32'h3;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        if (c != 32) bad++;
        check("ign_result", result, model(3'd0, 32'h1234, 32'h5678));
      end
    end
    check("ign_timing", bad, 0);
    check("ign_ndone", ndone, 1);

    // asynchronous reset mid-CALC
    @(negedge clk);
    start = 1'b1; funct3 = 3'd3; dataA = 32'hFFFF_0000; dataB = 32'h1234_0000;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done || busy) ndone++;
    end
    check("arst_no_done", ndone, 0);
    do_op("arst_mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle();

    // start held high: back-to-back ops with no idle gap
    @(negedge clk);
    start = 1'b1; funct3 = 3'd0; dataA = 32'd3; dataB = 32'd5;
    bad = 0;
    ndone = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      if (done !== (c == 32 || c == 65 || c == 98)) bad++;
      if (busy === done) bad++;
      if (done) begin
        ndone++;
        if (result !== 32'h0000_000F) bad++;
      end
    end
    @(negedge clk);
    start = 1'b0;
    check("b2b_pattern", bad, 0);
    check("b2b_ndone", ndone, 3);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
